// File: rtl/tjmono_hitor_tdc_pkg.sv
// tjmono_hitor_tdc_pkg: word-type codes, ToT limit, FSM encoding and word packers for the HITOR TDC
package tjmono_hitor_tdc_pkg;
  localparam logic WORD_TYPE_HIT = 1'b0;
  localparam logic WORD_TYPE_TSH = 1'b1;
  localparam logic [11:0] TOT_MAX = 12'hFFF;
  typedef enum logic {IDLE, HIGH} state_t;
  function automatic logic [31:0] hit_word(input logic [3:0] id, input logic [14:0] ts, input logic [11:0] tot);
    return {id, WORD_TYPE_HIT, ts, tot};
  endfunction
  function automatic logic [31:0] tsh_word(input logic [3:0] id, input logic [26:0] ts_hi);
    return {id, WORD_TYPE_TSH, ts_hi};
  endfunction
endpackage

// File: rtl/tjmono_hitor_tdc_if.sv
// tjmono_hitor_tdc_if: FWFT FIFO read port (read in, empty/data out) between the TDC and an arbiter
interface tjmono_hitor_tdc_if;
  logic read;
  logic empty;
  logic [31:0] data;
  modport master (input read, output empty, data);
  modport slave (output read, input empty, data);
endinterface

// File: rtl/tjmono_hitor_tdc_fifo.sv
// tjmono_hitor_tdc_fifo: first-word-fall-through FIFO; ports clk, rst, wr_en/wr_data, rd_en, full, empty, rd_data
module tjmono_hitor_tdc_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] rd_data
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0] wr_ptr, rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // head word is forced to zero while empty so the output is defined out of reset
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  always_ff @(posedge clk)
    if (wr_en) mem[wr_ptr[AW-1:0]] <= wr_data;
endmodule

// File: rtl/tjmono_hitor_tdc.sv
// tjmono_hitor_tdc: HITOR leading-edge timestamp + ToT measurement packed into 32-bit words in a FWFT FIFO
// ports: clk, rst (async, active-high), enable, hitor (async), lost_cnt (saturating drops), fifo (master read port)
module tjmono_hitor_tdc
  import tjmono_hitor_tdc_pkg::*;
#(
  parameter logic [3:0] IDENTIFIER = 4'b0001,
  parameter int         DEPTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      enable,
  input  logic                      hitor,
  output logic [7:0]                lost_cnt,
  tjmono_hitor_tdc_if.master        fifo
);
  logic sync_q, hit_s, hit_d, rise, fall;
  logic [41:0] ts;
  state_t state, state_n;
  logic [14:0] ts_lat, ts_lat_n;
  logic [11:0] tot, tot_n;
  logic hit_vld, hit_vld_n, ts_pend;
  logic [26:0] tsh_val;
  logic wr_vld, full, pop, push;
  logic [31:0] wr_data;
  assign rise = hit_s & ~hit_d;
  assign fall = ~hit_s & hit_d;
  assign pop = fifo.read & ~fifo.empty;
  assign push = wr_vld & (~full | pop);
  always_comb begin
    state_n = state;
    ts_lat_n = ts_lat;
    tot_n = tot;
    hit_vld_n = 1'b0;
    if (!enable) state_n = IDLE;
    else if (state == IDLE) begin
      if (rise) begin
        state_n = HIGH;
        ts_lat_n = ts[14:0];
        tot_n = 12'd1;
      end
    end else if (fall) begin
      state_n = IDLE;
      hit_vld_n = 1'b1;
    end else if (hit_s && tot != TOT_MAX) tot_n = tot + 12'd1;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {sync_q, hit_s, hit_d} <= '0;
      ts <= '0;
      state <= IDLE;
      ts_lat <= '0;
      tot <= '0;
      hit_vld <= 1'b0;
      ts_pend <= 1'b0;
      tsh_val <= '0;
      wr_vld <= 1'b0;
      wr_data <= '0;
      lost_cnt <= '0;
    end else begin
      {sync_q, hit_s, hit_d} <= {hitor, sync_q, hit_s};
      ts <= ts + 42'd1;
      state <= state_n;
      ts_lat <= ts_lat_n;
      tot <= tot_n;
      hit_vld <= hit_vld_n;
      // payload is the upper TS of the value the counter takes at the low-half wrap
      if (&ts[14:0]) tsh_val <= ts[41:15] + 27'd1;
      // a pending TS-high word survives only while a hit word holds the write slot
      ts_pend <= enable & ((&ts[14:0]) | (ts_pend & hit_vld));
      // ts_lat/tot stay frozen until the next rise, which cannot land before this write
      wr_vld <= hit_vld | (ts_pend & enable);
      wr_data <= hit_vld ? hit_word(IDENTIFIER, ts_lat, tot) : tsh_word(IDENTIFIER, tsh_val);
      if (wr_vld && !push && !(&lost_cnt)) lost_cnt <= lost_cnt + 8'd1;
    end
  tjmono_hitor_tdc_fifo #(.DEPTH(DEPTH), .WIDTH(32)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr_en(push),
    .wr_data(wr_data),
    .rd_en(pop),
    .full(full),
    .empty(fifo.empty),
    .rd_data(fifo.data)
  );
endmodule
